ddr_txn_sequencer: RTL and testbench
====================================

Name: ddr_txn_sequencer

Overview:
- Upstream control stage for the PL_DDR_RW AXI master.
- Issues INIT_AXI_TXN pulses, waits for each TXN_DONE rising edge and samples TXN_ERROR.
- Runs a programmable number of iterations, with a timeout guard and saturating pass/fail/timeout statistics.
- Replaces the testbench-driven init pulse so on-chip DDR soak tests run standalone.

Parameters:
ITER_W, 16, width of iteration count and iteration index
CNT_W, 16, width of pass/fail/timeout counters (saturating)
INIT_PULSE_CYCLES, 2, cycles init_axi_txn_o is held high (>=1)
TIMEOUT_CYCLES, 1000000, max cycles in WAIT_DONE before declaring timeout (>=1)
GAP_CYCLES, 16, idle cycles between iterations (0 allowed)
STOP_ON_FAIL, 1, 1 = finish after first error/timeout; 0 = continue

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset; asynchronous, active-low
start  in  1  single-cycle start request; honoured only in IDLE
abort  in  1  level/pulse; forces FINISH from any non-IDLE state
num_iter  in  ITER_W  iteration count, sampled on accepted start; 0 = run until abort
txn_done_i  in  1  from master DDR_AXI_TXN_DONE
txn_error_i  in  1  from master DDR_AXI_ERROR
init_axi_txn_o  out  1  to master DDR_AXI_INIT_AXI_TXN
busy  out  1  high in every state except IDLE
seq_done  out  1  high from FINISH until next accepted start
seq_pass  out  1  valid when seq_done; 1 iff fail_cnt==0 and timeout_cnt==0
iter_cnt  out  ITER_W  completed iterations (wraps at 2^ITER_W only when num_iter==0)
pass_cnt  out  CNT_W  iterations finished with done and no error
fail_cnt  out  CNT_W  iterations with error or timeout
timeout_cnt  out  CNT_W  iterations ended by timeout
first_fail_iter  out  ITER_W  1-based index of first failing iteration; 0 = none

Behaviour:
- Reset (ARESETN low, asynchronous): state IDLE; all outputs 0; timers and done_q cleared. Reset mid-transaction drops all state immediately. The master is reset by the same ARESETN.
- States: IDLE, PULSE, WAIT_DONE, GAP, FINISH.
- IDLE:
  - start=1 -> PULSE next cycle.
  - Same edge: latch num_iter; clear iter_cnt, all counters, first_fail_iter, seq_done, seq_pass.
  - start while busy is ignored.
- PULSE:
  - init_axi_txn_o=1 for exactly INIT_PULSE_CYCLES cycles, registered output.
  - Then -> WAIT_DONE with timer=0.
- WAIT_DONE:
  - done_q is a registered copy of txn_done_i, updated every cycle.
  - Rising edge = txn_done_i & ~done_q. A stale high DONE from the previous run is never counted.
  - On rising edge: sample txn_error_i the same cycle; iter_cnt+1; pass_cnt+1 if no error, else fail_cnt+1.
  - If timer reaches TIMEOUT_CYCLES-1 with no edge: timeout_cnt+1, fail_cnt+1, iter_cnt+1.
  - Edge and timeout in the same cycle: edge wins.
- After each iteration ends:
  - On the first failure, if first_fail_iter==0, load it with the new iter_cnt value.
  - Next state: FINISH if (num_iter!=0 and new iter_cnt==num_iter) or (fail and STOP_ON_FAIL), else GAP.
  - GAP_CYCLES==0 goes straight to PULSE.
- GAP: count GAP_CYCLES cycles -> PULSE.
- abort:
  - Any of PULSE/WAIT_DONE/GAP -> FINISH next cycle.
  - init_axi_txn_o drops the same edge; the master tolerates truncation because it edge-detects init.
  - An in-flight iteration is not counted.
  - abort and an iteration end in the same cycle: the counters update, then FINISH.
- FINISH (one cycle): set seq_done=1; seq_pass=(fail_cnt==0 && timeout_cnt==0) using post-update values; -> IDLE.
- Counters: pass/fail/timeout saturate at all-ones and never wrap.
- Outputs: all registered; no combinational path from input to output.

Decomposition:
- Package ddr_seq_pkg:
  - state_t enum (IDLE, PULSE, WAIT_DONE, GAP, FINISH).
  - localparam TMR_W = $clog2(max(TIMEOUT_CYCLES, GAP_CYCLES, INIT_PULSE_CYCLES)+1).
  - Function sat_inc for saturating increment.
- Sub-module ddr_seq_sat_counter (WIDTH param; clr, inc, count; async active-low reset), instantiated three times.
- The FSM, timer and edge detect stay in the top module.

Test Plan:
1. num_iter=3; slave model raises DONE 50 cycles after each init, ERROR=0 -> three 2-cycle init pulses 16+ cycles apart; pass_cnt=3, fail_cnt=0, iter_cnt=3, seq_done=1, seq_pass=1.
2. num_iter=4, STOP_ON_FAIL=1, ERROR=1 on iteration 2 -> exactly 2 init pulses; pass_cnt=1, fail_cnt=1, first_fail_iter=2, seq_pass=0.
3. TIMEOUT_CYCLES=100, DONE held 0, num_iter=1 -> FINISH 100 cycles after WAIT_DONE entry; timeout_cnt=1, fail_cnt=1, iter_cnt=1, seq_pass=0.
4. DONE already high at start, model drops it 2 cycles after init then re-raises at cycle 40 -> exactly one iteration counted, at the re-rise; never at the stale level.
5. num_iter=0, abort asserted 10 cycles into the 5th WAIT_DONE -> FINISH next cycle; iter_cnt=4; init_axi_txn_o low; busy low two cycles after abort.
6. ARESETN low for 1 cycle mid-WAIT_DONE, asynchronous to the clock edge -> all outputs 0 immediately; a start after release runs a fresh sequence with counters from 0.

Source files
------------

// File: rtl/ddr_seq_pkg.sv
// ddr_seq_pkg: state encoding and helpers shared by the DDR transaction sequencer
package ddr_seq_pkg;
  typedef enum logic [2:0] {IDLE, PULSE, WAIT_DONE, GAP, FINISH} state_t;
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = w >= 32 ? '1 : (32'd1 << w) - 32'd1;
    return v == top ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/ddr_seq_sat_counter.sv
// ddr_seq_sat_counter: clearable event counter that sticks at all-ones
module ddr_seq_sat_counter
  import ddr_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= WIDTH'(sat_inc(32'(count), WIDTH));
endmodule

// File: rtl/ddr_txn_sequencer.sv
// ddr_txn_sequencer: drives repeated INIT_AXI_TXN pulses into the DDR AXI master
// and gathers pass/fail/timeout statistics for standalone soak runs.
module ddr_txn_sequencer
  import ddr_seq_pkg::*;
#(
  parameter int ITER_W            = 16,
  parameter int CNT_W             = 16,
  parameter int INIT_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 1000000,
  parameter int GAP_CYCLES        = 16,
  parameter int STOP_ON_FAIL      = 1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] num_iter,
  input  logic              txn_done_i,
  input  logic              txn_error_i,
  output logic              init_axi_txn_o,
  output logic              busy,
  output logic              seq_done,
  output logic              seq_pass,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic [ITER_W-1:0] first_fail_iter
);
  localparam int TMR_W = tmr_width(TIMEOUT_CYCLES, GAP_CYCLES, INIT_PULSE_CYCLES);
  state_t state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [ITER_W-1:0] num_q;
  logic done_q;
  logic in_wait, rise, tmo, it_end, it_fail, last, accept, run;
  logic [ITER_W-1:0] iter_nx;
  assign in_wait = state == WAIT_DONE;
  // a DONE level left over from an earlier run never counts, only a fresh rise
  assign rise    = in_wait & txn_done_i & ~done_q;
  assign tmo     = in_wait & ~rise & (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign it_end  = rise | tmo;
  assign it_fail = (rise & txn_error_i) | tmo;
  assign iter_nx = iter_cnt + 1'b1;
  assign last    = (num_q != '0) && (iter_nx == num_q);
  assign accept  = (state == IDLE) && start;
  assign run     = (state == PULSE) || (state == WAIT_DONE) || (state == GAP);
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        state_n = start ? PULSE : IDLE;
      end
      PULSE: if (timer == TMR_W'(INIT_PULSE_CYCLES - 1)) begin
        state_n = WAIT_DONE;
        timer_n = '0;
      end
      WAIT_DONE: if (it_end) begin
        state_n = (last || (it_fail && STOP_ON_FAIL != 0)) ? FINISH :
                  (GAP_CYCLES == 0) ? PULSE : GAP;
        timer_n = '0;
      end
      GAP: if (timer == TMR_W'(GAP_CYCLES - 1)) begin
        state_n = PULSE;
        timer_n = '0;
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
    if (run && abort) state_n = FINISH;
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state           <= IDLE;
      timer           <= '0;
      done_q          <= 1'b0;
      num_q           <= '0;
      init_axi_txn_o  <= 1'b0;
      busy            <= 1'b0;
      seq_done        <= 1'b0;
      seq_pass        <= 1'b0;
      iter_cnt        <= '0;
      first_fail_iter <= '0;
    end else begin
      state          <= state_n;
      timer          <= timer_n;
      done_q         <= txn_done_i;
      init_axi_txn_o <= state_n == PULSE;
      busy           <= state_n != IDLE;
      if (accept) begin
        num_q           <= num_iter;
        iter_cnt        <= '0;
        first_fail_iter <= '0;
        seq_done        <= 1'b0;
        seq_pass        <= 1'b0;
      end
      if (it_end) iter_cnt <= iter_nx;
      if (it_fail && first_fail_iter == '0) first_fail_iter <= iter_nx;
      if (state == FINISH) begin
        seq_done <= 1'b1;
        seq_pass <= (fail_cnt == '0) && (timeout_cnt == '0);
      end
    end
  ddr_seq_sat_counter #(.WIDTH(CNT_W)) u_pass (
    .clk(ACLK), .rst_n(ARESETN), .clr(accept), .inc(rise & ~txn_error_i), .count(pass_cnt)
  );
  ddr_seq_sat_counter #(.WIDTH(CNT_W)) u_fail (
    .clk(ACLK), .rst_n(ARESETN), .clr(accept), .inc(it_fail), .count(fail_cnt)
  );
  ddr_seq_sat_counter #(.WIDTH(CNT_W)) u_tmo (
    .clk(ACLK), .rst_n(ARESETN), .clr(accept), .inc(tmo), .count(timeout_cnt)
  );
endmodule

// File: tb/tb_ddr_txn_sequencer.sv
// tb_ddr_txn_sequencer: randomized soak scenarios against an iteration-level outcome model,
// with a small DDR master stand-in answering each init pulse.
module tb_ddr_txn_sequencer;
  logic ACLK = 0, ARESETN = 0, start = 0, abort = 0;
  logic [15:0] num_iter = 0;
  logic txn_done_i, txn_error_i;
  logic init_axi_txn_o, busy, seq_done, seq_pass;
  logic [15:0] iter_cnt, pass_cnt, fail_cnt, timeout_cnt, first_fail_iter;
  int total = 0, bad = 0, cyc = 0;
  int dly_a [16];
  bit err_a [16];
  int pulses = 0, bad_w = 0, bad_gap = 0, last_rise = 0, cur_w = 0, slv_cnt = 0, slv_dly = 0;
  bit slv_err = 0, init_d = 0;
  logic [15:0] exp_iter, exp_pass, exp_fail, exp_tmo, exp_ff;

  ddr_txn_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort), .num_iter(num_iter),
    .txn_done_i(txn_done_i), .txn_error_i(txn_error_i), .init_axi_txn_o(init_axi_txn_o),
    .busy(busy), .seq_done(seq_done), .seq_pass(seq_pass), .iter_cnt(iter_cnt),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
    .first_fail_iter(first_fail_iter)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // master stand-in: clears DONE 2 cycles after an init rise, raises it after dly_a[k] (0 = never)
  initial begin
    txn_done_i = 0;
    txn_error_i = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        txn_done_i = 0; txn_error_i = 0; slv_dly = 0; init_d = 0; cur_w = 0;
      end else begin
        if (init_axi_txn_o && !init_d) begin
          if (pulses > 0 && cyc - last_rise < 18) bad_gap++;
          last_rise = cyc;
          slv_dly = pulses < 16 ? dly_a[pulses] : 0;
          slv_err = pulses < 16 ? err_a[pulses] : 1'b0;
          pulses++;
          slv_cnt = 0;
        end
        if (init_axi_txn_o) cur_w++;
        else if (init_d) begin
          if (cur_w != 2) bad_w++;
          cur_w = 0;
        end
        slv_cnt++;
        if (slv_cnt == 2) begin txn_done_i = 0; txn_error_i = 0; end
        if (slv_dly > 0 && slv_cnt == slv_dly) begin txn_done_i = 1; txn_error_i = slv_err; end
        init_d = init_axi_txn_o;
      end
    end
  end

  // expected outcome of a run with STOP_ON_FAIL=1, one entry per iteration
  task automatic model(input int n);
    bit fl;
    exp_iter = 0; exp_pass = 0; exp_fail = 0; exp_tmo = 0; exp_ff = 0;
    for (int i = 0; i < 16; i++) begin
      fl = dly_a[i] == 0 || err_a[i];
      exp_iter++;
      if (dly_a[i] == 0) exp_tmo++;
      if (fl) exp_fail++; else exp_pass++;
      if (fl && exp_ff == 0) exp_ff = exp_iter;
      if (exp_iter == 16'(n) || fl) break;
    end
  endtask

  task automatic start_seq(input int n);
    @(negedge ACLK);
    pulses = 0; bad_w = 0; bad_gap = 0;
    num_iter = 16'(n);
    start = 1;
    @(negedge ACLK);
    start = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (seq_done === 1'b1) begin ok = 1; break; end
      @(negedge ACLK);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge ACLK);
    total++; if ({init_axi_txn_o, busy, seq_done, seq_pass} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {init_axi_txn_o, busy, seq_done, seq_pass}); end
    total++; if ({iter_cnt, pass_cnt, fail_cnt, timeout_cnt, first_fail_iter} !== 80'b0) begin bad++; $display("FAIL reset_counts got=%h exp=0", {iter_cnt, pass_cnt, fail_cnt, timeout_cnt, first_fail_iter}); end
    ARESETN = 1;
    @(negedge ACLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    bit ok;
    for (int i = 0; i < 16; i++) begin dly_a[i] = 50; err_a[i] = 0; end
    model(3);
    start_seq(3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=%0d exp=%0d", ok, 1); end
    total++; if (pulses !== 3) begin bad++; $display("FAIL basic_pulses got=%0d exp=3", pulses); end
    total++; if (bad_w !== 0 || bad_gap !== 0) begin bad++; $display("FAIL basic_shape got=%0d/%0d exp=0/0", bad_w, bad_gap); end
    total++; if ({iter_cnt, pass_cnt, fail_cnt, timeout_cnt} !== {exp_iter, exp_pass, exp_fail, exp_tmo}) begin bad++; $display("FAIL basic_counts got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", iter_cnt, pass_cnt, fail_cnt, timeout_cnt, exp_iter, exp_pass, exp_fail, exp_tmo); end
    total++; if ({seq_pass, busy, first_fail_iter} !== {1'b1, 1'b0, 16'd0}) begin bad++; $display("FAIL basic_status got=%b/%b/%0d exp=1/0/0", seq_pass, busy, first_fail_iter); end
  endtask

  task automatic test_stop_on_fail;
    bit ok;
    for (int i = 0; i < 16; i++) begin dly_a[i] = $urandom_range(10, 60); err_a[i] = i == 1; end
    model(4);
    start_seq(4);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL stop_timeout got=%0d exp=%0d", ok, 1); end
    total++; if (pulses !== 2) begin bad++; $display("FAIL stop_pulses got=%0d exp=2", pulses); end
    total++; if ({iter_cnt, pass_cnt, fail_cnt, first_fail_iter} !== {exp_iter, exp_pass, exp_fail, exp_ff}) begin bad++; $display("FAIL stop_counts got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", iter_cnt, pass_cnt, fail_cnt, first_fail_iter, exp_iter, exp_pass, exp_fail, exp_ff); end
    total++; if (seq_pass !== 1'b0) begin bad++; $display("FAIL stop_seq_pass got=%b exp=0", seq_pass); end
  endtask

  task automatic test_timeout;
    bit ok;
    int c0;
    for (int i = 0; i < 16; i++) begin dly_a[i] = 0; err_a[i] = 0; end
    model(1);
    start_seq(1);
    for (int i = 0; i < 10; i++) begin
      if (!init_axi_txn_o) break;
      @(negedge ACLK);
    end
    c0 = cyc;
    wait_done(ok);
    total++; if (cyc - c0 !== 101) begin bad++; $display("FAIL tmo_latency got=%0d exp=101", cyc - c0); end
    total++; if ({iter_cnt, fail_cnt, timeout_cnt, first_fail_iter} !== {exp_iter, exp_fail, exp_tmo, exp_ff}) begin bad++; $display("FAIL tmo_counts got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", iter_cnt, fail_cnt, timeout_cnt, first_fail_iter, exp_iter, exp_fail, exp_tmo, exp_ff); end
    total++; if (seq_pass !== 1'b0) begin bad++; $display("FAIL tmo_seq_pass got=%b exp=0", seq_pass); end
  endtask

  task automatic test_stale_done;
    bit ok;
    for (int i = 0; i < 16; i++) begin dly_a[i] = 40; err_a[i] = 0; end
    @(negedge ACLK);
    txn_done_i = 1;
    start_seq(1);
    repeat (20) @(negedge ACLK);
    total++; if ({busy, iter_cnt} !== {1'b1, 16'd0}) begin bad++; $display("FAIL stale_early got=%b/%0d exp=1/0", busy, iter_cnt); end
    wait_done(ok);
    total++; if ({pulses == 1, iter_cnt, pass_cnt, seq_pass} !== {1'b1, 16'd1, 16'd1, 1'b1}) begin bad++; $display("FAIL stale_counts got=%0d/%0d/%0d/%b exp=1/1/1/1", pulses, iter_cnt, pass_cnt, seq_pass); end
  endtask

  task automatic test_random;
    bit ok;
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < 16; i++) begin
        dly_a[i] = $urandom_range(0, 4) == 0 ? 0 : $urandom_range(10, 60);
        err_a[i] = $urandom_range(0, 3) == 0;
      end
      model(n);
      start_seq(n);
      wait_done(ok);
      total++; if (!ok || pulses !== int'(exp_iter)) begin bad++; $display("FAIL rand%0d_pulses got=%0d exp=%0d", r, pulses, exp_iter); end
      total++; if ({iter_cnt, pass_cnt, fail_cnt, timeout_cnt, first_fail_iter} !== {exp_iter, exp_pass, exp_fail, exp_tmo, exp_ff}) begin bad++; $display("FAIL rand%0d_counts got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d", r, iter_cnt, pass_cnt, fail_cnt, timeout_cnt, first_fail_iter, exp_iter, exp_pass, exp_fail, exp_tmo, exp_ff); end
      total++; if (seq_pass !== (exp_fail == 0)) begin bad++; $display("FAIL rand%0d_seq_pass got=%b exp=%b", r, seq_pass, exp_fail == 0); end
      total++; if (bad_w !== 0) begin bad++; $display("FAIL rand%0d_width got=%0d exp=0", r, bad_w); end
    end
  endtask

  task automatic test_abort;
    bit ok;
    for (int i = 0; i < 16; i++) begin dly_a[i] = 30; err_a[i] = 0; end
    start_seq(0);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ACLK);
      if (pulses == 5 && !init_axi_txn_o) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL abort_reach got=%0d exp=%0d", pulses, 5); end
    repeat (9) @(negedge ACLK);
    abort = 1;
    @(negedge ACLK);
    abort = 0;
    total++; if ({busy, init_axi_txn_o, seq_done} !== 3'b100) begin bad++; $display("FAIL abort_finish got=%b exp=100", {busy, init_axi_txn_o, seq_done}); end
    @(negedge ACLK);
    total++; if ({busy, seq_done, seq_pass} !== 3'b011) begin bad++; $display("FAIL abort_idle got=%b exp=011", {busy, seq_done, seq_pass}); end
    total++; if ({iter_cnt, pass_cnt, fail_cnt} !== {16'd4, 16'd4, 16'd0}) begin bad++; $display("FAIL abort_counts got=%0d/%0d/%0d exp=4/4/0", iter_cnt, pass_cnt, fail_cnt); end
  endtask

  task automatic test_async_reset;
    bit ok;
    for (int i = 0; i < 16; i++) begin dly_a[i] = 50; err_a[i] = 0; end
    start_seq(3);
    for (int i = 0; i < 2000; i++) begin
      @(negedge ACLK);
      if (pulses == 2 && !init_axi_txn_o) break;
    end
    repeat (5) @(negedge ACLK);
    total++; if (busy !== 1'b1 || iter_cnt !== 16'd1) begin bad++; $display("FAIL arst_pre got=%b/%0d exp=1/1", busy, iter_cnt); end
    #2 ARESETN = 0;
    #1;
    total++; if ({init_axi_txn_o, busy, seq_done, seq_pass, iter_cnt, pass_cnt, fail_cnt, timeout_cnt, first_fail_iter} !== 84'b0) begin bad++; $display("FAIL arst_outputs got=%h exp=0", {init_axi_txn_o, busy, seq_done, seq_pass, iter_cnt, pass_cnt, fail_cnt, timeout_cnt, first_fail_iter}); end
    #9 ARESETN = 1;
    for (int i = 0; i < 16; i++) begin dly_a[i] = $urandom_range(10, 60); err_a[i] = 0; end
    model(2);
    start_seq(2);
    wait_done(ok);
    total++; if (!ok || {iter_cnt, pass_cnt, fail_cnt, seq_pass} !== {exp_iter, exp_pass, exp_fail, 1'b1}) begin bad++; $display("FAIL arst_fresh got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/1", iter_cnt, pass_cnt, fail_cnt, seq_pass, exp_iter, exp_pass, exp_fail); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stop_on_fail;
    test_timeout;
    test_stale_done;
    test_random;
    test_abort;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
